spi_master_param: RTL and testbench
===================================

// Module: spi_master_param
// PURPOSE
//  Parametrised SPI master for the SoC peripheral bus: configurable frame length up to DW bits, all four
//  CPOL/CPHA modes, MSB- or LSB-first, NUM_SS active-low slave selects with optional hold between frames,
//  and abort. Successor to the fixed 8-bit SPI core; sits behind the SPI register wrapper.
// PARAMETERS
//  DW      16  max frame width in bits (>=2)
//  NUM_SS  4   number of slave-select outputs (>=1)
//  DVSR_W  16  width of clock divisor
// PORTS
//  clk            in   1              system clock
//  reset          in   1              synchronous, active-high reset
//  din            in   DW             tx data, right-justified (bits [len-1:0] used)
//  dvsr           in   DVSR_W         half-period = dvsr+1 clk cycles
//  frame_len      in   $clog2(DW+1)   bits per frame; 0 or >DW treated as DW
//  cpol, cpha     in   1              SPI mode
//  lsb_first      in   1              1: bit 0 shifted first
//  ss_sel         in   $clog2(NUM_SS) slave to select (min width 1)
//  ss_hold        in   1              keep ss_n asserted after this frame
//  start          in   1              begin frame; accepted only while ready=1
//  abort          in   1              terminate current frame
//  dout           out  DW             rx data, right-justified, upper bits 0
//  spi_done_tick  out  1              1-cycle pulse, dout valid
//  ready          out  1              1 only in IDLE
//  sclk, mosi     out  1              SPI clock / data out (registered)
//  miso           in   1              SPI data in
//  ss_n           out  NUM_SS         active-low selects (registered)
// BEHAVIOUR
//  - Reset: state IDLE; dout=0, spi_done_tick=0, ready=1, sclk=0, mosi=0, ss_n=all 1, counters 0.
//  - start&ready latches din, dvsr, len, cpol, cpha, lsb_first, ss_sel, ss_hold into shadow regs;
//    live inputs ignored until next IDLE. start while ready=0 is ignored.
//  - States: IDLE -> SETUP -> {P0 -> P1} x len -> HOLD -> DONE -> IDLE. Each of SETUP/P0/P1/HOLD lasts
//    exactly dvsr+1 cycles (half-period tick from sub-module); DONE lasts 1 cycle.
//  - ss_n[ss_sel] driven low from first SETUP cycle to end of DONE; ss_sel>=NUM_SS selects none, frame
//    still runs. sclk=cpol in IDLE/SETUP/P0/HOLD/DONE, ~cpol in P1 (leading edge P0->P1, trailing P1->P0/HOLD).
//  - cpha=0: mosi = first bit from SETUP; miso sampled at leading edge; mosi advances at trailing edge
//    (not after last bit). cpha=1: mosi updates at each leading edge; miso sampled at trailing edge.
//  - MSB-first: din[len-1] sent first; received bits shift in at bit 0. LSB-first: din[0] first;
//    first received bit lands in dout[0]. dout updated only in DONE, same cycle as spi_done_tick.
//  - Frame length in clk cycles = (2*len+2)*(dvsr+1)+1 from start to done tick (+1 to ready).
//  - ss_hold=1 latched: ss_n stays low through IDLE until next accepted start; if that start's ss_sel
//    differs, old select released and new one asserted in same cycle. Frame with ss_hold=0 releases at DONE.
//  - abort (any non-IDLE state): next cycle IDLE, ss_n all 1, sclk=cpol, no done tick, dout unchanged.
//    abort in IDLE releases a held select. abort wins over start in same cycle.
//  - dvsr=0: 1-cycle half-periods; counter compares ==dvsr, never wraps mid-half-period.
//  - reset mid-frame: immediate return to reset values next edge.
// STRUCTURE
//  - spi_pkg: state enum spi_state_t {IDLE,SETUP,P0,P1,HOLD,DONE}, mode struct {cpol,cpha,lsb_first}.
//  - Sub-module spi_half_tick: DVSR_W counter, clear on state change, outputs tick when count==dvsr.
//  - Top: FSM, tx/rx shift regs (DW), bit counter, ss_n/sclk/mosi output regs.
// TESTING
//  1 Mode 0, DW=16, len=8, dvsr=3, din=0x00A5, miso loopback -> sclk 8 rising edges, mosi 1,0,1,0,0,1,0,1,
//    dout=0x00A5, done tick at cycle 73 after start.
//  2 All modes (cpol,cpha)=00..11, len=16, din=0xC3F0, slave model drives 0x1234 -> dout=0x1234, sclk idles
//    at cpol, sample edge matches mode.
//  3 lsb_first=1, len=5, din=0x13 -> mosi 1,1,0,0,1; loopback dout=0x0013, dout[15:5]=0.
//  4 ss_hold=1 frame on ss_sel=2 then frame on ss_sel=2 ss_hold=0 -> ss_n=4'b1011 continuous across both,
//    then 4'b1111; second test switches to ss_sel=1 -> 1011 -> 1101 in one cycle.
//  5 abort mid P1 of bit 3 -> next cycle ss_n=4'b1111, ready=1, no done tick, dout unchanged; start ignored
//    while busy; frame_len=0 sends 16 bits; dvsr=0 frame takes 35 cycles for len=16.
//  6 reset asserted mid-frame -> all outputs at reset values next cycle; new frame completes correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM states, per-frame mode bits,
// and a width helper that keeps select indices at least one bit wide.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, P0, P1, HOLD, DONE} spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Bus-side bundle of the SPI master: frame request/config in, rx data/status and SPI pins out.
// master = the SPI core's view; slave = the register wrapper / driver view.
interface spi_master_param_if import spi_pkg::*; #(
    parameter int DW     = 16,
    parameter int NUM_SS = 4,
    parameter int DVSR_W = 16
) ();
    localparam int LEN_W = $clog2(DW + 1);
    localparam int SS_W  = min1_clog2(NUM_SS);

    logic [DW-1:0]     din;
    logic [DVSR_W-1:0] dvsr;
    logic [LEN_W-1:0]  frame_len;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [SS_W-1:0]   ss_sel;
    logic              ss_hold;
    logic              start;
    logic              abort;
    logic [DW-1:0]     dout;
    logic              spi_done_tick;
    logic              ready;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_SS-1:0] ss_n;

    modport master (
        input  din, dvsr, frame_len, cpol, cpha, lsb_first, ss_sel, ss_hold, start, abort, miso,
        output dout, spi_done_tick, ready, sclk, mosi, ss_n
    );

    modport slave (
        output din, dvsr, frame_len, cpol, cpha, lsb_first, ss_sel, ss_hold, start, abort, miso,
        input  dout, spi_done_tick, ready, sclk, mosi, ss_n
    );
endinterface

// File: rtl/spi_half_tick.sv
// Half-period timer: counts from 0 and ticks when the count equals dvsr (dvsr+1 cycles per tick).
// Cleared by the FSM on every state change, so it never wraps mid half-period.
module spi_half_tick #(
    parameter int DVSR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic              tick_o
);
    logic [DVSR_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : cnt_q + DVSR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == dvsr_i);
endmodule

// File: rtl/spi_master_param.sv
// SPI master: one frame per accepted start, (2*len+2)*(dvsr+1)+1 cycles from start to done tick.
// start is taken only in IDLE (ready=1); abort returns to IDLE on the next edge without a done tick.
module spi_master_param import spi_pkg::*; #(
    parameter int DW     = 16,
    parameter int NUM_SS = 4,
    parameter int DVSR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    spi_master_param_if.master bus
);
    localparam int LEN_W = $clog2(DW + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DW);

    typedef logic [DW-1:0] word_t;

    spi_state_t        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;
    logic [LEN_W-1:0]  len_q, len_d, bit_q, bit_d, len_in;
    logic              hold_q, hold_d;
    word_t             tx_q, tx_d, rx_q, rx_d, dout_q, dout_d, tx_load, rx_shift;
    logic              mosi_q, mosi_d, sclk_q, sclk_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d, ss_n_sel;
    logic              tick, last_bit;

    spi_half_tick #(.DVSR_W(DVSR_W)) u_half_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  ((state_q == IDLE) || (state_d != state_q)),
        .dvsr_i (dvsr_q),
        .tick_o (tick)
    );

    assign len_in   = (bus.frame_len == '0 || bus.frame_len > LEN_MAX) ? LEN_MAX : bus.frame_len;
    assign last_bit = (bit_q == len_q - LEN_W'(1));

    // tx shift register always emits from its MSB: left-justify MSB-first data, bit-reverse LSB-first
    always_comb begin
        tx_load = bus.din << (LEN_MAX - len_in);
        if (bus.lsb_first) begin
            for (int i = 0; i < DW; i++) tx_load[i] = bus.din[DW-1-i];
        end
    end

    always_comb begin
        ss_n_sel = '1;
        if (32'(bus.ss_sel) < NUM_SS) ss_n_sel[bus.ss_sel] = 1'b0;
    end

    assign rx_shift = mode_q.lsb_first ? {bus.miso, rx_q[DW-1:1]} : {rx_q[DW-2:0], bus.miso};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dvsr_d  = dvsr_q;
        len_d   = len_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        mosi_d  = mosi_q;
        ss_n_d  = ss_n_q;
        case (state_q)
            IDLE: begin
                if (bus.abort) begin
                    ss_n_d = '1;
                end else if (bus.start) begin
                    state_d          = SETUP;
                    mode_d.cpol      = bus.cpol;
                    mode_d.cpha      = bus.cpha;
                    mode_d.lsb_first = bus.lsb_first;
                    dvsr_d           = bus.dvsr;
                    len_d            = len_in;
                    hold_d           = bus.ss_hold;
                    bit_d            = '0;
                    rx_d             = '0;
                    ss_n_d           = ss_n_sel;
                    tx_d             = tx_load;
                    if (!bus.cpha) begin
                        mosi_d = tx_load[DW-1];
                        tx_d   = tx_load << 1;
                    end
                end
            end
            SETUP: if (tick) state_d = P0;
            P0: if (tick) begin
                state_d = P1;
                if (mode_q.cpha) begin
                    mosi_d = tx_q[DW-1];
                    tx_d   = tx_q << 1;
                end else begin
                    rx_d = rx_shift;
                end
            end
            P1: if (tick) begin
                if (mode_q.cpha) rx_d = rx_shift;
                if (last_bit) begin
                    state_d = HOLD;
                end else begin
                    state_d = P0;
                    bit_d   = bit_q + LEN_W'(1);
                    if (!mode_q.cpha) begin
                        mosi_d = tx_q[DW-1];
                        tx_d   = tx_q << 1;
                    end
                end
            end
            HOLD: if (tick) begin
                state_d = DONE;
                dout_d  = mode_q.lsb_first ? (rx_q >> (LEN_MAX - len_q)) : rx_q;
            end
            DONE: begin
                state_d = IDLE;
                if (!hold_q) ss_n_d = '1;
            end
            default: state_d = IDLE;
        endcase
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            ss_n_d  = '1;
            dout_d  = dout_q;
        end
        sclk_d = (state_d == P1) ? ~mode_d.cpol : mode_d.cpol;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= '0;
            dvsr_q  <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            hold_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
            ss_n_q  <= '1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dvsr_q  <= dvsr_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            ss_n_q  <= ss_n_d;
        end
    end

    assign bus.dout          = dout_q;
    assign bus.spi_done_tick = (state_q == DONE);
    assign bus.ready         = (state_q == IDLE);
    assign bus.sclk          = sclk_q;
    assign bus.mosi          = mosi_q;
    assign bus.ss_n          = ss_n_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Directed + random frames against an edge-level SPI slave model; expectations from frame arithmetic.
module tb_spi_master_param;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [3:0] held_ssn;
    logic       bad;

    spi_master_param_if #(.DW(16), .NUM_SS(4), .DVSR_W(16)) bus_if ();

    spi_master_param #(.DW(16), .NUM_SS(4), .DVSR_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame: slave returns sw in the frame's bit order; mosi bits recorded at each leading sclk edge.
    task automatic run_frame(input logic [15:0] d, input logic [4:0] fl, input logic [15:0] dv,
                             input logic cp, input logic ph, input logic lsb, input logic [1:0] sel,
                             input logic hold, input logic [15:0] sw, input int abort_bit,
                             input logic poke);
        int          L, k, lead, cyc, exp_cyc, dones;
        logic [15:0] exp_bits, got_bits, sbits, dout_before;
        logic [16:0] m17;
        logic        prev_sclk, ss_bad, done_seen, aborted;
        logic [3:0]  ss_exp;
        L        = (fl == 0 || fl > 16) ? 16 : int'(fl);
        exp_bits = '0;
        got_bits = '0;
        sbits    = '0;
        for (int i = 0; i < L; i++) begin
            exp_bits[i] = lsb ? d[i]  : d[L-1-i];
            sbits[i]    = lsb ? sw[i] : sw[L-1-i];
        end
        m17     = (17'd1 << L) - 17'd1;
        exp_cyc = (2 * L + 2) * (int'(dv) + 1) + 1;
        ss_exp  = ~(4'b0001 << sel);
        chk("idle_ss", bus_if.ss_n, held_ssn);
        chk("idle_ready", bus_if.ready, 1);
        bus_if.din = d; bus_if.frame_len = fl; bus_if.dvsr = dv;
        bus_if.cpol = cp; bus_if.cpha = ph; bus_if.lsb_first = lsb;
        bus_if.ss_sel = sel; bus_if.ss_hold = hold;
        bus_if.miso = ph ? 1'b0 : sbits[0];
        bus_if.start = 1'b1;
        dout_before = bus_if.dout;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.din = ~d; bus_if.frame_len = fl + 5'd1; bus_if.dvsr = dv + 16'd5;
        bus_if.cpol = ~cp; bus_if.cpha = ~ph; bus_if.lsb_first = ~lsb;
        bus_if.ss_sel = sel + 2'd1; bus_if.ss_hold = ~hold;
        chk("ss_first", bus_if.ss_n, ss_exp);
        cyc = 1; k = ph ? 0 : 1; lead = 0; prev_sclk = cp;
        ss_bad = 1'b0; done_seen = 1'b0; aborted = 1'b0;
        while (cyc < 2000) begin
            if (bus_if.spi_done_tick === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            if (bus_if.ss_n !== ss_exp) ss_bad = 1'b1;
            if (bus_if.sclk !== prev_sclk) begin
                if (bus_if.sclk !== cp) begin
                    if (lead < 16) got_bits[lead] = bus_if.mosi;
                    lead++;
                    if (ph && k < L) begin bus_if.miso = sbits[k]; k++; end
                    if (lead == abort_bit + 1) begin
                        bus_if.abort = 1'b1;
                        @(negedge clk);
                        bus_if.abort = 1'b0;
                        aborted = 1'b1;
                        break;
                    end
                end else if (!ph && k < L) begin
                    bus_if.miso = sbits[k];
                    k++;
                end
                prev_sclk = bus_if.sclk;
            end
            bus_if.start = (poke && cyc == 5);
            @(negedge clk);
            cyc++;
        end
        bus_if.start = 1'b0;
        if (aborted) begin
            chk("abort_ss", bus_if.ss_n, 4'hF);
            chk("abort_ready", bus_if.ready, 1);
            chk("abort_sclk", bus_if.sclk, cp);
            chk("abort_dout", bus_if.dout, dout_before);
            dones = 0;
            repeat (4) begin
                if (bus_if.spi_done_tick !== 1'b0) dones++;
                @(negedge clk);
            end
            chk("abort_no_done", dones, 0);
            held_ssn = 4'hF;
        end else begin
            chk("done_seen", done_seen, 1);
            chk("frame_cycles", cyc, exp_cyc);
            chk("dout", bus_if.dout, {16'h0, sw & m17[15:0]});
            chk("mosi_bits", got_bits, exp_bits);
            chk("sclk_edges", lead, L);
            chk("ss_during", ss_bad, 0);
            chk("ss_in_done", bus_if.ss_n, ss_exp);
            chk("sclk_idle", bus_if.sclk, cp);
            @(negedge clk);
            chk("ready_after", bus_if.ready, 1);
            chk("done_one_cycle", bus_if.spi_done_tick, 0);
            held_ssn = hold ? ss_exp : 4'hF;
            chk("ss_after", bus_if.ss_n, held_ssn);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; held_ssn = 4'hF; bad = 1'b0;
        reset = 1'b1;
        bus_if.din = '0; bus_if.dvsr = '0; bus_if.frame_len = '0; bus_if.cpol = 1'b0;
        bus_if.cpha = 1'b0; bus_if.lsb_first = 1'b0; bus_if.ss_sel = '0; bus_if.ss_hold = 1'b0;
        bus_if.start = 1'b0; bus_if.abort = 1'b0; bus_if.miso = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus_if.ready, 1);
        chk("rst_ss", bus_if.ss_n, 4'hF);
        chk("rst_sclk", bus_if.sclk, 0);
        chk("rst_mosi", bus_if.mosi, 0);
        chk("rst_dout", bus_if.dout, 0);
        chk("rst_done", bus_if.spi_done_tick, 0);

        // mode 0, 8 bits, dvsr=3: done tick at cycle 73
        run_frame(16'h00A5, 5'd8, 16'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h00A5, -1, 1'b0);
        // all four modes, with a start poked mid-frame
        for (int m = 0; m < 4; m++)
            run_frame(16'hC3F0, 5'd16, 16'd1, m[1], m[0], 1'b0, 2'(m), 1'b0, 16'h1234, -1, 1'b1);
        // LSB-first, 5 bits
        run_frame(16'h0013, 5'd5, 16'd2, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 16'h0013, -1, 1'b0);

        // held select continuous across frames and the idle gap
        run_frame(16'h5A5A, 5'd8, 16'd1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 16'h00C3, -1, 1'b0);
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.ss_n !== 4'b1011) bad = 1'b1;
        end
        chk("hold_gap", bad, 0);
        run_frame(16'h0F0F, 5'd8, 16'd1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h003C, -1, 1'b0);
        run_frame(16'h1111, 5'd8, 16'd0, 1'b1, 1'b1, 1'b0, 2'd2, 1'b1, 16'h0081, -1, 1'b0);
        run_frame(16'h2222, 5'd8, 16'd0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 16'h007E, -1, 1'b0);
        // abort in IDLE releases a held select
        run_frame(16'h3333, 5'd4, 16'd0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 16'h0009, -1, 1'b0);
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.abort = 1'b0;
        chk("idle_abort_ss", bus_if.ss_n, 4'hF);
        held_ssn = 4'hF;

        // abort during P1 of bit 3
        run_frame(16'hBEEF, 5'd8, 16'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h5A5A, 3, 1'b0);
        // frame_len=0 -> 16 bits; dvsr=0 len=16 -> 35 cycles
        run_frame(16'h8001, 5'd0, 16'd1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 16'hA55A, -1, 1'b0);
        run_frame(16'h7E81, 5'd16, 16'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'hFFFF, -1, 1'b0);

        // reset in the middle of a frame
        bus_if.din = 16'hFFFF; bus_if.frame_len = 5'd16; bus_if.dvsr = 16'd2;
        bus_if.cpol = 1'b1; bus_if.cpha = 1'b0; bus_if.ss_sel = 2'd2; bus_if.ss_hold = 1'b1;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", bus_if.ready, 1);
        chk("midrst_ss", bus_if.ss_n, 4'hF);
        chk("midrst_sclk", bus_if.sclk, 0);
        chk("midrst_mosi", bus_if.mosi, 0);
        chk("midrst_dout", bus_if.dout, 0);
        chk("midrst_done", bus_if.spi_done_tick, 0);
        held_ssn = 4'hF;
        @(negedge clk);
        run_frame(16'h0B6D, 5'd12, 16'd1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 16'h0ACE, -1, 1'b0);

        for (int n = 0; n < 40; n++)
            run_frame(16'($urandom), 5'($urandom_range(0, 31)), 16'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                      16'($urandom), -1, 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
